// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle chunked add/subtract unit with NZCV flags
module addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_negative,
   output logic             out_zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  x_q, y_q, res_q, res_d;
   logic [WIDTH-1:0]  x_sel, y_sel;
   logic              cin_sel;
   logic              carry_q;
   logic [KW-1:0]     k_q;
   logic              c_q, v_q, n_q, z_q;
   logic [CHUNK:0]    slice_sum;
   logic              last_slice;

   // Operand steering: every op reduces to X + Y + cin
   always_comb begin
      x_sel   = in_data0;
      y_sel   = in_data1;
      cin_sel = 1'b0;
      case (in_op)
         3'b001: cin_sel = in_carry;
         3'b010: begin y_sel = ~in_data1; cin_sel = 1'b1; end
         3'b011: begin y_sel = ~in_data1; cin_sel = in_carry; end
         3'b100: begin x_sel = in_data1; y_sel = ~in_data0; cin_sel = 1'b1; end
         3'b101: begin x_sel = in_data1; y_sel = ~in_data0; cin_sel = in_carry; end
         default: ;
      endcase
   end

   // One chunk of the ripple: current slice plus the registered running carry
   always_comb begin
      slice_sum  = {1'b0, x_q[k_q*CHUNK +: CHUNK]} + {1'b0, y_q[k_q*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(carry_q);
      last_slice = (k_q == KW'(N - 1));
      res_d      = res_q;
      res_d[k_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)   state_d = CALC;
         CALC:    if (last_slice) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs; in_ready is held low for the whole reset pulse
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == DONE);
   end

   // Datapath: latch operands on accept, accumulate one slice per CALC cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q     <= x_sel;
                  y_q     <= y_sel;
                  carry_q <= cin_sel;
                  k_q     <= '0;
               end
            end
            CALC: begin
               res_q   <= res_d;
               carry_q <= slice_sum[CHUNK];
               k_q     <= k_q + KW'(1);
               if (last_slice) begin
                  c_q <= slice_sum[CHUNK];
                  v_q <= (x_q[WIDTH-1] == y_q[WIDTH-1]) && (res_d[WIDTH-1] != x_q[WIDTH-1]);
                  n_q <= res_d[WIDTH-1];
                  z_q <= (res_d == '0);
               end
            end
            default: ;
         endcase
      end
   end

   // Result and flags come straight from registers
   always_comb begin
      out_data     = res_q;
      out_carry    = c_q;
      out_overflow = v_q;
      out_negative = n_q;
      out_zero     = z_q;
   end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle add/subtract unit with full NZCV flag generation and operation select. It computes one WIDTH-bit result per transaction, CHUNK bits per cycle, and gives correct carry semantics for all add and subtract variants. It sits in the CPU execute stage alongside the single-cycle ALU and serves wide or area-constrained arithmetic through a valid/ready handshake on both sides.

## Interface
- WIDTH, 32: operand and result width; must be ≥ 2.
- CHUNK, 8: bits processed per cycle; WIDTH % CHUNK must equal 0; N = WIDTH/CHUNK.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  operation select (see Operation).
- in_data0  in  WIDTH  operand A.
- in_data1  in  WIDTH  operand B.
- in_carry  in  1  carry flag input; used only by ADC/SBC/RSC.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_carry  out  1  C flag.
- out_overflow  out  1  V flag.
- out_negative  out  1  N flag, out_data[WIDTH-1].
- out_zero  out  1  Z flag, out_data == 0.

## Operation
- Each op is X + Y + cin over WIDTH bits:
  - 000 ADD: X=A, Y=B, cin=0.
  - 001 ADC: X=A, Y=B, cin=in_carry.
  - 010 SUB: X=A, Y=~B, cin=1.
  - 011 SBC: X=A, Y=~B, cin=in_carry.
  - 100 RSB: X=B, Y=~A, cin=1.
  - 101 RSC: X=B, Y=~A, cin=in_carry.
  - 110/111: treated as ADD.
- X, Y and cin are latched at acceptance. Input ports are don't-care afterwards.
- out_carry is the true carry out of bit WIDTH-1 of X+Y+cin. For subtract variants, 1 means no borrow.
- out_overflow = (X[W-1] == Y[W-1]) && (out_data[W-1] != X[W-1]).
- FSM states:
  - IDLE: in_ready=1. When in_valid is high, latch operands, clear the chunk index and set the running carry to cin, then go to CALC.
  - CALC: each cycle, add slice [k*CHUNK +: CHUNK] of X and Y plus the running carry, write the sum slice into the result register, update the running carry, and increment k. After slice N-1, register all flags and go to DONE.
  - DONE: out_valid=1. When out_ready is high, go to IDLE.
- in_ready is high only in IDLE and is forced low while rst is high. No request is accepted in CALC or DONE.
- out_data and all flags hold their last values after the output handshake, until the next result is written.

## Timing
- Reset (asynchronous) sets:
  - state to IDLE;
  - out_valid to 0;
  - out_data to 0;
  - out_carry, out_overflow, out_negative and out_zero to 0;
  - chunk index and running carry to 0.
- Asserting rst during CALC or DONE aborts the transaction. No out_valid is produced for it. After rst deasserts, in_ready=1 in the first cycle.
- Latency: for a request accepted on edge E, out_valid is high from edge E+N onward, so it is visible in the cycle after the last CALC edge. For N=1 (CHUNK==WIDTH), out_valid is high right after E+1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and the flags are stable and in_ready=0.
- Throughput with out_ready tied high: one result every N+2 cycles (accept, N CALC cycles, DONE).
- Carry ripples across chunk boundaries only through the registered running carry. There is no combinational path from inputs to outputs.
- Simultaneous events:
  - in_valid in DONE is ignored, because in_ready=0.
  - in_valid together with rst is ignored.

## Test plan
- SUB, A=5, B=3 (WIDTH=32, CHUNK=8): out_data=2, C=1, V=0, N=0, Z=0. out_valid rises exactly 4 cycles after the accept edge.
- SUB, A=3, B=5: out_data=0xFFFFFFFE, C=0, N=1. SUB, A=0x80000000, B=1: out_data=0x7FFFFFFF, V=1, C=1.
- ADD, A=0xFFFFFFFF, B=1: out_data=0, C=1, Z=1, V=0, which checks carry ripple through all chunks. ADD, A=0x7FFFFFFF, B=1: out_data=0x80000000, V=1, N=1.
- Carry-in variants:
  - SBC, A=5, B=3, in_carry=0: out_data=1, C=1.
  - RSB, A=3, B=10: out_data=7.
  - RSC, A=3, B=10, in_carry=0: out_data=6.
  - ADC, A=1, B=1, in_carry=1: out_data=3.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE: outputs stable, in_ready=0, and the result is accepted on the first out_ready=1.
  - Assert rst mid-CALC: all outputs read 0, out_valid never rises, and the next request completes normally.
- Parameter sweep: WIDTH=16, CHUNK=16, SUB A=0, B=1 gives 0xFFFF, C=0, N=1 with 1-cycle latency. WIDTH=64, CHUNK=4 matches a reference model over 1000 random ops with 16-cycle latency.
